// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, scheduler state encoding and ROB sizing defaults
package alu_pkg;

    localparam logic [3:0] COP_MOV = 4'b0011;
    localparam logic [3:0] COP_LD  = 4'b0110;
    localparam logic [3:0] COP_ST  = 4'b0111;
    localparam logic [3:0] COP_MUL = 4'b1000;

    localparam int ROB_DEPTH_DEF = 8;
    localparam int TAIL_W_DEF    = 3;

    typedef enum logic {
        RUN   = 1'b0,
        MULTI = 1'b1
    } sched_state_t;

endpackage

// File: rtl/rob_credit_ctr.sv
// rtl/rob_credit_ctr.sv - saturating ROB credit counter with sticky over-retire flag
module rob_credit_ctr
    import alu_pkg::*;
#(
    parameter int DEPTH = ROB_DEPTH_DEF,
    parameter int CW    = TAIL_W_DEF + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          take,
    input  logic          give,
    output logic [CW-1:0] credits,
    output logic          credit_err
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            credits    <= FULL;
            credit_err <= 1'b0;
        end else if (clear) begin
            credits <= FULL;
        end else if (take && !give) begin
            credits <= credits - CW'(1);
        end else if (give && !take) begin
            // a retire with every slot already free means the ROB and scheduler disagree
            if (credits == FULL) begin
                credit_err <= 1'b1;
            end else begin
                credits <= credits + CW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_issue_sched.sv
// rtl/alu_issue_sched.sv - ALU stage issue scheduler; ALU_ISSUE_PERF_EN adds stall counters
module alu_issue_sched
    import alu_pkg::*;
#(
    parameter int         ROB_DEPTH  = ROB_DEPTH_DEF,
    parameter int         TAIL_W     = TAIL_W_DEF,
    parameter int         MUL_CYCLES = 4,
    parameter logic [3:0] MULTI_COP  = COP_MUL
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dec_valid,
    input  logic [3:0]        dec_cop,
    output logic              dec_ready,
    input  logic              flush,
    input  logic              rob_retire,
    output logic              enable_alu,
    output logic [TAIL_W-1:0] tail_rob,
    output logic              result_valid,
    output logic              credit_err
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [15:0]       perf_stall_rob,
    output logic [15:0]       perf_stall_multi
`endif
);

    localparam int CW     = TAIL_W + 1;
    localparam int WAIT_W = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES) : 1;

    sched_state_t      state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CW-1:0]     credits;

    assign dec_ready  = reset && (state == RUN) && (credits != '0) && !flush;
    assign enable_alu = dec_valid && dec_ready;

    rob_credit_ctr #(
        .DEPTH (ROB_DEPTH),
        .CW    (CW)
    ) u_credit (
        .clk        (clk),
        .reset      (reset),
        .clear      (flush),
        .take       (enable_alu),
        .give       (rob_retire),
        .credits    (credits),
        .credit_err (credit_err)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= RUN;
            wait_cnt     <= '0;
            tail_rob     <= '0;
            result_valid <= 1'b0;
        end else if (flush) begin
            // an in-flight multi-cycle op is dropped without ever signalling a result
            state        <= RUN;
            wait_cnt     <= '0;
            result_valid <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (enable_alu) begin
                        tail_rob <= tail_rob + TAIL_W'(1);
                        if (dec_cop == MULTI_COP) begin
                            state        <= MULTI;
                            wait_cnt     <= WAIT_W'(MUL_CYCLES - 1);
                            result_valid <= 1'b0;
                        end else begin
                            result_valid <= 1'b1;
                        end
                    end else begin
                        result_valid <= 1'b0;
                    end
                end
                MULTI: begin
                    wait_cnt <= wait_cnt - WAIT_W'(1);
                    if (wait_cnt == WAIT_W'(1)) begin
                        state        <= RUN;
                        result_valid <= 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef ALU_ISSUE_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_rob   <= '0;
            perf_stall_multi <= '0;
        end else begin
            if (dec_valid && (credits == '0) && (perf_stall_rob != 16'hFFFF)) begin
                perf_stall_rob <= perf_stall_rob + 16'd1;
            end
            if (dec_valid && (state == MULTI) && (perf_stall_multi != 16'hFFFF)) begin
                perf_stall_multi <= perf_stall_multi + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_sched.sv
// tb/tb_alu_issue_sched.sv - per-cycle vector table plus reset-during-MULTI sequence
module tb_alu_issue_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       dec_valid;
    logic [3:0] dec_cop;
    logic       dec_ready;
    logic       flush;
    logic       rob_retire;
    logic       enable_alu;
    logic [2:0] tail_rob;
    logic       result_valid;
    logic       credit_err;
`ifdef ALU_ISSUE_PERF_EN
    logic [15:0] perf_stall_rob;
    logic [15:0] perf_stall_multi;
`endif

    int checks   = 0;
    int failures = 0;

    alu_issue_sched dut (
        .clk          (clk),
        .reset        (reset),
        .dec_valid    (dec_valid),
        .dec_cop      (dec_cop),
        .dec_ready    (dec_ready),
        .flush        (flush),
        .rob_retire   (rob_retire),
        .enable_alu   (enable_alu),
        .tail_rob     (tail_rob),
        .result_valid (result_valid),
        .credit_err   (credit_err)
`ifdef ALU_ISSUE_PERF_EN
        ,
        .perf_stall_rob   (perf_stall_rob),
        .perf_stall_multi (perf_stall_multi)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [3:0] cop;
        logic       fl;
        logic       ret;
        logic       rdy;
        logic       en;
        logic [2:0] tail;
        logic       rv;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic [3:0] cop, input logic fl, input logic ret,
                       input logic rdy, input logic en, input logic [2:0] tail,
                       input logic rv, input logic err);
        vec_t r;
        r.v = v; r.cop = cop; r.fl = fl; r.ret = ret;
        r.rdy = rdy; r.en = en; r.tail = tail; r.rv = rv; r.err = err;
        vecs.push_back(r);
    endtask

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=%0h expected=%0h", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input logic rdy, input logic en, input logic [2:0] tail,
                           input logic rv, input logic err);
        chk("dec_ready",    idx, {7'd0, dec_ready},    {7'd0, rdy});
        chk("enable_alu",   idx, {7'd0, enable_alu},   {7'd0, en});
        chk("tail_rob",     idx, {5'd0, tail_rob},     {5'd0, tail});
        chk("result_valid", idx, {7'd0, result_valid}, {7'd0, rv});
        chk("credit_err",   idx, {7'd0, credit_err},   {7'd0, err});
    endtask

    task automatic drive(input logic v, input logic [3:0] cop, input logic fl, input logic ret);
        dec_valid = v; dec_cop = cop; flush = fl; rob_retire = ret;
    endtask

    initial begin
        // 8 back-to-back issues from reset, then ROB-full stall
        for (int k = 0; k < 8; k++) add(1, 4'h0, 0, 0, 1, 1, 3'(k), (k != 0), 0);
        add(1, 4'h0, 0, 0, 0, 0, 3'd0, 1, 0);
        add(1, 4'h0, 0, 0, 0, 0, 3'd0, 0, 0);
        // stalled at zero credits; retire lifts the stall for one issue
        for (int k = 0; k < 4; k++) add(1, 4'h0, 0, 0, 0, 0, 3'd0, 0, 0);
        add(1, 4'h0, 0, 1, 0, 0, 3'd0, 0, 0);
        add(1, 4'h0, 0, 0, 1, 1, 3'd0, 0, 0);
        add(1, 4'h0, 0, 0, 0, 0, 3'd1, 1, 0);
        // three retires, then issue+retire together keeps credits at 3
        add(0, 4'h0, 0, 1, 0, 0, 3'd1, 0, 0);
        add(0, 4'h0, 0, 1, 1, 0, 3'd1, 0, 0);
        add(0, 4'h0, 0, 1, 1, 0, 3'd1, 0, 0);
        add(1, 4'h0, 0, 1, 1, 1, 3'd1, 0, 0);
        add(1, 4'h0, 0, 0, 1, 1, 3'd2, 1, 0);
        add(1, 4'h0, 0, 0, 1, 1, 3'd3, 1, 0);
        add(1, 4'h0, 0, 0, 1, 1, 3'd4, 1, 0);
        add(1, 4'h0, 0, 0, 0, 0, 3'd5, 1, 0);
        // flush refills credits; full MUL op with decode held valid
        add(1, 4'h0, 1, 0, 0, 0, 3'd5, 0, 0);
        add(1, 4'h8, 0, 0, 1, 1, 3'd5, 0, 0);
        for (int k = 0; k < 3; k++) add(1, 4'h0, 0, 0, 0, 0, 3'd6, 0, 0);
        add(1, 4'h0, 0, 0, 1, 1, 3'd6, 1, 0);
        add(0, 4'h0, 0, 0, 1, 0, 3'd7, 1, 0);
        // MUL aborted by flush two cycles in
        add(1, 4'h8, 0, 0, 1, 1, 3'd7, 0, 0);
        add(1, 4'h0, 0, 0, 0, 0, 3'd0, 0, 0);
        add(1, 4'h0, 1, 0, 0, 0, 3'd0, 0, 0);
        for (int k = 0; k < 3; k++) add(0, 4'h0, 0, 0, 1, 0, 3'd0, 0, 0);
        // retire at full: sticky error, credits still exactly 8
        add(0, 4'h0, 0, 1, 1, 0, 3'd0, 0, 0);
        add(0, 4'h0, 0, 0, 1, 0, 3'd0, 0, 1);
        for (int k = 0; k < 8; k++) add(1, 4'h0, 0, 0, 1, 1, 3'(k), (k != 0), 1);
        add(1, 4'h0, 0, 0, 0, 0, 3'd0, 1, 1);

        reset = 1'b0;
        drive(1, 4'h0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk_all(-1, 0, 0, 3'd0, 0, 0);

        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            if (i != 0) @(negedge clk);
            drive(vecs[i].v, vecs[i].cop, vecs[i].fl, vecs[i].ret);
            #1;
            chk_all(i, vecs[i].rdy, vecs[i].en, vecs[i].tail, vecs[i].rv, vecs[i].err);
        end

        // reset asserted mid-MULTI: immediate defaults, no late result
        @(negedge clk);
        drive(0, 4'h0, 1, 0);
        #1;
        chk("h_flush_rdy", 100, {7'd0, dec_ready}, 8'd0);
        @(negedge clk);
        drive(1, 4'h8, 0, 0);
        #1;
        chk("h_mul_issue", 101, {7'd0, enable_alu}, 8'd1);
        @(negedge clk);
        drive(1, 4'h0, 0, 0);
        #1;
        chk("h_multi_rdy", 102, {7'd0, dec_ready}, 8'd0);
        chk("h_multi_tail", 102, {5'd0, tail_rob}, 8'd1);
        reset = 1'b0;
        #1;
        chk_all(103, 0, 0, 3'd0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        drive(0, 4'h0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk_all(104 + k, 1, 0, 3'd0, 0, 0);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
